// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI arbiter: FSM states, slave-select codes
// and requester indices.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [2:0] SS_TRIG = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

  localparam logic [1:0] REQ_CMD  = 2'd0;
  localparam logic [1:0] REQ_DUMP = 2'd1;
  localparam logic [1:0] REQ_CAL  = 2'd2;

endpackage

// File: rtl/spi_arb_rr_arb3.sv
// Three-way round-robin arbiter. The requester granted last time gets the
// lowest priority; the pointer itself lives in the caller.
module rr_arb3
  import spi_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       advance,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  // Pick the first requester after the last-granted one, only when advancing
  always_comb begin
    gnt = 3'b000;
    if (advance) begin
      case (last)
        REQ_CMD: begin
          if      (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        REQ_DUMP: begin
          if      (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if      (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Arbitrates three requesters onto one SPI master, one transaction at a
// time, with a timeout guard on the SPI_done handshake.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] wdata2,
  input  logic [2:0]  ss0,
  input  logic [2:0]  ss1,
  input  logic [2:0]  ss2,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] SPI_data,
  output logic        wrt_SPI,
  output logic [2:0]  ss,
  input  logic        SPI_done,
  input  logic [7:0]  EEP_data
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_gnt;
  logic [2:0]       arb_gnt;
  logic [15:0]      sel_data;
  logic [2:0]       sel_ss;
  logic [1:0]       sel_idx;

  rr_arb3 u_arb (
    .req     (req),
    .advance (state == IDLE),
    .last    (last_gnt),
    .gnt     (arb_gnt)
  );

  // Route the winning requester's command word and slave select
  always_comb begin
    sel_data = wdata0;
    sel_ss   = ss0;
    sel_idx  = REQ_CMD;
    case (arb_gnt)
      3'b010: begin
        sel_data = wdata1;
        sel_ss   = ss1;
        sel_idx  = REQ_DUMP;
      end
      3'b100: begin
        sel_data = wdata2;
        sel_ss   = ss2;
        sel_idx  = REQ_CAL;
      end
      default: ;
    endcase
  end

  // Transaction FSM; strobes default low so each is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      done     <= 3'b000;
      err      <= 1'b0;
      wrt_SPI  <= 1'b0;
      rdata    <= 8'h00;
      SPI_data <= 16'h0000;
      ss       <= 3'b000;
      cnt      <= '0;
      last_gnt <= REQ_CAL;
    end else begin
      wrt_SPI <= 1'b0;
      done    <= 3'b000;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            gnt      <= arb_gnt;
            SPI_data <= sel_data;
            ss       <= sel_ss;
            last_gnt <= sel_idx;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          wrt_SPI <= 1'b1;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (SPI_done) begin
            rdata <= EEP_data;
            done  <= gnt;
            state <= FINISH;
          end else if (cnt == CNT_MAX) begin
            done  <= gnt;
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          gnt   <= 3'b000;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: a default-timeout instance and a TIMEOUT_CYC=16
// instance share stimulus; a round-robin/rdata model predicts outputs.
module tb_spi_arb;
  import spi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [2:0]  ss0, ss1, ss2;
  logic        SPI_done;
  logic [7:0]  EEP_data;

  logic [2:0]  gnt_d, done_d, ss_d, gnt_t, done_t, ss_t;
  logic        err_d, wrt_d, err_t, wrt_t;
  logic [7:0]  rdata_d, rdata_t;
  logic [15:0] spi_data_d, spi_data_t;

  logic        use_to = 1'b0;
  logic [2:0]  gnt_o, done_o, ss_o;
  logic        err_o, wrt_o;
  logic [7:0]  rdata_o;
  logic [15:0] spi_data_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          last_g;
  logic [7:0]  exp_rdata;

  spi_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ss0(ss0), .ss1(ss1), .ss2(ss2),
    .gnt(gnt_d), .done(done_d), .err(err_d), .rdata(rdata_d),
    .SPI_data(spi_data_d), .wrt_SPI(wrt_d), .ss(ss_d),
    .SPI_done(SPI_done), .EEP_data(EEP_data)
  );

  spi_arb #(.TIMEOUT_CYC(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ss0(ss0), .ss1(ss1), .ss2(ss2),
    .gnt(gnt_t), .done(done_t), .err(err_t), .rdata(rdata_t),
    .SPI_data(spi_data_t), .wrt_SPI(wrt_t), .ss(ss_t),
    .SPI_done(SPI_done), .EEP_data(EEP_data)
  );

  assign gnt_o      = use_to ? gnt_t      : gnt_d;
  assign done_o     = use_to ? done_t     : done_d;
  assign ss_o       = use_to ? ss_t       : ss_d;
  assign err_o      = use_to ? err_t      : err_d;
  assign wrt_o      = use_to ? wrt_t      : wrt_d;
  assign rdata_o    = use_to ? rdata_t    : rdata_d;
  assign spi_data_o = use_to ? spi_data_t : spi_data_d;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pickWinner(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic resetAll();
    rst_n = 1'b0;
    req = 3'b000;
    SPI_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    last_g = 2;
    exp_rdata = 8'h00;
    tick();
  endtask

  // One full transaction: request, grant, launch, SPI_done (or timeout), finish
  task automatic applyStimulus(input logic [2:0] r, input int delay, input logic [7:0] eep,
                               input bit perturb, input bit timeout, input bit spur);
    int          win;
    int          cyc;
    logic [2:0]  exp_g;
    logic [15:0] w;
    logic [2:0]  s;
    req = r;
    win = pickWinner(r, last_g);
    exp_g = 3'(1 << win);
    w = (win == 0) ? wdata0 : (win == 1) ? wdata1 : wdata2;
    s = (win == 0) ? ss0 : (win == 1) ? ss1 : ss2;
    if (spur) SPI_done = 1'b1;
    tick();
    checkOutput("gnt", 32'(gnt_o), 32'(exp_g));
    checkOutput("spi_data", 32'(spi_data_o), 32'(w));
    checkOutput("ss", 32'(ss_o), 32'(s));
    checkOutput("wrt_before_launch", 32'(wrt_o), 0);
    last_g = win;
    tick();
    SPI_done = 1'b0;
    checkOutput("wrt_launch", 32'(wrt_o), 1);
    checkOutput("done_in_launch", 32'(done_o), 0);
    if (perturb) begin
      req = ~r;
      wdata0 = ~wdata0; wdata1 = ~wdata1; wdata2 = ~wdata2;
      ss0 = ~ss0; ss1 = ~ss1; ss2 = ~ss2;
    end
    if (timeout) begin
      cyc = 0;
      while (done_o == 3'b000 && cyc < 40) begin
        tick();
        cyc++;
      end
      checkOutput("timeout_cycles", 32'(cyc), 16);
      checkOutput("timeout_done", 32'(done_o), 32'(exp_g));
      checkOutput("timeout_err", 32'(err_o), 1);
      checkOutput("timeout_rdata", 32'(rdata_o), 32'(exp_rdata));
    end else begin
      for (int k = 1; k < delay; k++) begin
        tick();
        checkOutput("wait_done", 32'(done_o), 0);
        checkOutput("wait_wrt", 32'(wrt_o), 0);
      end
      SPI_done = 1'b1;
      EEP_data = eep;
      tick();
      SPI_done = 1'b0;
      EEP_data = 8'($urandom);
      exp_rdata = eep;
      checkOutput("done", 32'(done_o), 32'(exp_g));
      checkOutput("err_clear", 32'(err_o), 0);
      checkOutput("rdata", 32'(rdata_o), 32'(exp_rdata));
      checkOutput("spi_data_held", 32'(spi_data_o), 32'(w));
      checkOutput("ss_held", 32'(ss_o), 32'(s));
    end
    req = r & ~exp_g;
    tick();
    checkOutput("done_pulse_end", 32'(done_o), 0);
    checkOutput("err_pulse_end", 32'(err_o), 0);
    checkOutput("gnt_released", 32'(gnt_o), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 3'b000;
    wdata0 = 16'h0; wdata1 = 16'h0; wdata2 = 16'h0;
    ss0 = 3'b000; ss1 = 3'b000; ss2 = 3'b000;
    SPI_done = 1'b0;
    EEP_data = 8'h00;
    last_g = 2;
    exp_rdata = 8'h00;
    tick();
    tick();
    checkOutput("rst_gnt", 32'(gnt_d), 0);
    checkOutput("rst_done", 32'(done_d), 0);
    checkOutput("rst_err", 32'(err_d), 0);
    checkOutput("rst_wrt", 32'(wrt_d), 0);
    checkOutput("rst_rdata", 32'(rdata_d), 0);
    checkOutput("rst_spi_data", 32'(spi_data_d), 0);
    checkOutput("rst_ss", 32'(ss_d), 0);
    rst_n = 1'b1;
    tick();

    // SPI_done in IDLE must do nothing
    SPI_done = 1'b1;
    EEP_data = 8'hEE;
    tick();
    SPI_done = 1'b0;
    checkOutput("idle_spi_done_done", 32'(done_d), 0);
    checkOutput("idle_spi_done_rdata", 32'(rdata_d), 0);
    tick();

    $display("[TB] single request");
    wdata0 = 16'h1234;
    ss0 = SS_CH1;
    applyStimulus(3'b001, 20, 8'h5A, 1'b0, 1'b0, 1'b1);

    $display("[TB] round robin");
    resetAll();
    wdata0 = 16'hA001; wdata1 = 16'hB002; wdata2 = 16'hC003;
    ss0 = SS_TRIG; ss1 = SS_CH2; ss2 = SS_EEP;
    applyStimulus(3'b111, 4, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b110, 6, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 3, 8'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b011, 5, 8'h44, 1'b0, 1'b0, 1'b0);

    $display("[TB] inputs changed after grant");
    applyStimulus(3'b010, 7, 8'h55, 1'b1, 1'b0, 1'b0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 25; n++) begin
      wdata0 = 16'($urandom); wdata1 = 16'($urandom); wdata2 = 16'($urandom);
      ss0 = 3'($urandom); ss1 = 3'($urandom); ss2 = 3'($urandom);
      applyStimulus(3'($urandom_range(1, 7)), $urandom_range(1, 12), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during WAIT");
    wdata0 = 16'h7777;
    ss0 = SS_CH3;
    req = 3'b001;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_gnt", 32'(gnt_d), 0);
    checkOutput("midrst_done", 32'(done_d), 0);
    checkOutput("midrst_err", 32'(err_d), 0);
    checkOutput("midrst_wrt", 32'(wrt_d), 0);
    checkOutput("midrst_rdata", 32'(rdata_d), 0);
    checkOutput("midrst_spi_data", 32'(spi_data_d), 0);
    checkOutput("midrst_ss", 32'(ss_d), 0);
    req = 3'b000;
    tick();
    rst_n = 1'b1;
    last_g = 2;
    exp_rdata = 8'h00;
    SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("after_rst_done", 32'(done_d), 0);
      checkOutput("after_rst_gnt", 32'(gnt_d), 0);
      tick();
    end
    wdata2 = 16'hE2E2;
    ss2 = SS_EEP;
    applyStimulus(3'b100, 9, 8'h9C, 1'b0, 1'b0, 1'b0);

    $display("[TB] timeout instance");
    resetAll();
    use_to = 1'b1;
    wdata0 = 16'h0F0F; wdata1 = 16'h1E1E; wdata2 = 16'h2D2D;
    applyStimulus(3'b001, 5, 8'hC3, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b010, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'b100, 16, 8'h77, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 15, 8'h88, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
